// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage with a small decoded-entry FIFO.
//
// Instructions are decoded as they are accepted, and the buffer stores the
// decoded fields, so an accepted word appears at the output one cycle later.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload until that edge.
// in_ready never depends on out_ready in the same cycle.
//
// Ports:
//   clock, reset_n      single clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_insn is the raw instruction
//   flush               synchronous discard of everything buffered
//   out_valid/out_ready downstream handshake
//   out_opcode .. out_alu_op, out_imm, out_target, out_type, out_illegal
//                       decoded fields of the head entry (zero when idle)
//   decode_count        number of entries delivered downstream (wraps)
module decode_stage #(
  parameter int INSN_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_alu_op,
  output logic [DATA_W-1:0] out_imm,
  output logic [26:0]       out_target,
  output logic [3:0]        out_type,
  output logic              out_illegal,
  output logic [15:0]       decode_count
);

  localparam int CNT_W = 2;
  localparam int PTR_W = 1;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] imm;
    logic [26:0]       target;
    logic [3:0]        kind;     // one-hot {JII, JI, I, R}
    logic              illegal;
  } entry_t;

  entry_t           dec;
  entry_t           mem [DEPTH];
  entry_t           head_entry;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             ready_en;  // low in reset and until the first edge after it
  logic             in_fire;
  logic             out_fire;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Combinational decode of the incoming word.
  always_comb begin
    dec         = '0;
    dec.opcode  = in_insn[31:27];
    dec.rd      = in_insn[26:22];
    dec.rs      = in_insn[21:17];
    dec.rt      = in_insn[16:12];
    dec.shamt   = in_insn[11:7];
    dec.alu_op  = (in_insn[31:27] == 5'b00000) ? in_insn[6:2] : 5'b00000;
    dec.imm     = DATA_W'($signed(in_insn[16:0]));
    dec.target  = in_insn[26:0];
    case (in_insn[31:27])
      5'b00000: begin
        // R-type only defines alu_op 0..7
        if (in_insn[6:2] <= 5'd7) dec.kind = 4'b0001;
        else                      dec.illegal = 1'b1;
      end
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: dec.kind = 4'b0010;
      5'b00001, 5'b00011, 5'b10110, 5'b10101:           dec.kind = 4'b0100;
      5'b00100:                                         dec.kind = 4'b1000;
      default:                                          dec.illegal = 1'b1;
    endcase
  end

  assign in_ready = ready_en && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      decode_count <= '0;
      ready_en     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (in_fire) tail <= ptr_next(tail);
        if (out_fire) begin
          head         <= ptr_next(head);
          decode_count <= decode_count + 16'd1;
        end
        count <= count + CNT_W'(in_fire) - CNT_W'(out_fire);
      end
    end
  end

  // Payload storage needs no reset: it is only visible while count is nonzero.
  always_ff @(posedge clock) begin
    if (in_fire && !flush) mem[tail] <= dec;
  end

  assign head_entry = out_valid ? mem[head] : '0;

  assign out_opcode  = head_entry.opcode;
  assign out_rd      = head_entry.rd;
  assign out_rs      = head_entry.rs;
  assign out_rt      = head_entry.rt;
  assign out_shamt   = head_entry.shamt;
  assign out_alu_op  = head_entry.alu_op;
  assign out_imm     = head_entry.imm;
  assign out_target  = head_entry.target;
  assign out_type    = head_entry.kind;
  assign out_illegal = head_entry.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage, checked
// against a queue-based reference model of a two-entry decoded FIFO.
module tb_decode_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode, out_rd, out_rs, out_rt, out_shamt, out_alu_op;
  logic [31:0] out_imm;
  logic [26:0] out_target;
  logic [3:0]  out_type;
  logic        out_illegal;
  logic [15:0] decode_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [93:0] exp_q[$];
  int          exp_cnt = 0;
  bit          rdy_en  = 0;

  decode_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_shamt(out_shamt), .out_alu_op(out_alu_op), .out_imm(out_imm),
    .out_target(out_target), .out_type(out_type), .out_illegal(out_illegal),
    .decode_count(decode_count)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decoded record from the instruction-set rules, in the same order as
  // the observed output concatenation below.
  function automatic logic [93:0] ref_decode(input logic [31:0] w);
    int          opc = int'(w[31:27]);
    int          fn  = int'(w[6:2]);
    int          imm_v;
    int          alu;
    logic [31:0] imm;
    logic [3:0]  kind = 4'd0;
    logic        ill  = 1'b0;
    imm_v = int'(w[16:0]);
    if (imm_v >= 65536) imm_v = imm_v - 131072;
    imm = imm_v;
    if (opc == 0 && fn <= 7)               kind = 4'd1;
    else if (opc inside {5, 7, 8, 2, 6})   kind = 4'd2;
    else if (opc inside {1, 3, 22, 21})    kind = 4'd4;
    else if (opc == 4)                     kind = 4'd8;
    else                                   ill  = 1'b1;
    alu = (opc == 0) ? fn : 0;
    return {5'(opc), w[26:22], w[21:17], w[16:12], w[11:7], 5'(alu),
            imm, w[26:0], kind, ill};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r = $urandom;
    logic [4:0]  legal [10] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd1,
                                5'd3, 5'd22, 5'd4};
    if ($urandom_range(0, 3) != 0) r[31:27] = legal[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        exp_valid;
    logic        exp_rdy;
    logic [93:0] obs;
    exp_valid = (exp_q.size() != 0);
    exp_rdy   = rdy_en && (exp_q.size() < 2);
    obs = {out_opcode, out_rd, out_rs, out_rt, out_shamt, out_alu_op,
           out_imm, out_target, out_type, out_illegal};
    check("out_valid", 96'(out_valid), 96'(exp_valid));
    check("in_ready", 96'(in_ready), 96'(exp_rdy));
    check("fields", 96'(obs), exp_valid ? 96'(exp_q[0]) : 96'd0);
    check("decode_count", 96'(decode_count), 96'(exp_cnt));
  endtask

  // Driver: one cycle of stimulus, checked before the edge, model updated after.
  task automatic step(input logic v, input logic [31:0] insn, input logic ordy, input logic fl);
    bit in_f, out_f;
    @(negedge clock);
    in_valid  = v;
    in_insn   = insn;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    in_f  = v && rdy_en && (exp_q.size() < 2);
    out_f = (exp_q.size() != 0) && ordy;
    @(posedge clock);
    rdy_en = 1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_f) begin
        void'(exp_q.pop_front());
        exp_cnt = (exp_cnt + 1) % 65536;
      end
      if (in_f) exp_q.push_back(ref_decode(insn));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_insn   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #1;
    check_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("ready_before_first_edge", 96'(in_ready), 96'd0);
    @(posedge clock);
    rdy_en = 1;

    // addi r1,r1,5, then a stalled cycle showing it
    step(1'b1, 32'h2842_0005, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    // immediate with bit 16 clear, then R-type sub
    step(1'b1, 32'h2842_FFFF, 1'b1, 1'b0);
    step(1'b1, 32'h0008_3004, 1'b1, 1'b0);
    // negative immediate and an R-type alu_op above 7
    step(1'b1, 32'h2843_8000, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0020, 1'b1, 1'b0);
    drain();

    // Backpressure: two accepted, third held until space frees
    a = rand_insn(); b = rand_insn(); c = rand_insn();
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
    drain();

    // Streaming at one per cycle
    for (int i = 0; i < 20; i++) step(1'b1, rand_insn(), 1'b1, 1'b0);
    drain();

    // Illegal opcode
    step(1'b1, {5'b11111, 27'($urandom)}, 1'b1, 1'b0);
    drain();

    // Flush with a full buffer and a simultaneous attempted transfer
    step(1'b1, rand_insn(), 1'b0, 1'b0);
    step(1'b1, rand_insn(), 1'b0, 1'b0);
    step(1'b1, rand_insn(), 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), rand_insn(), 1'($urandom), ($urandom_range(0, 15) == 0));
    drain();

    // Asynchronous reset with two entries buffered
    step(1'b1, rand_insn(), 1'b0, 1'b0);
    step(1'b1, rand_insn(), 1'b0, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    rdy_en  = 0;
    #1;
    check_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    rdy_en = 1;
    step(1'b1, 32'h2842_0005, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
